// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes, the Z/V/N flag struct
// and the per-opcode flag write mask used by flag_unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GE  = 3'b100,
        CC_LE  = 3'b101,
        CC_OV  = 3'b110,
        CC_UNC = 3'b111
    } ccc_t;

    // Packed so that a 3-bit mask {z, v, n} lines up bit-for-bit with the struct.
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    localparam logic [2:0] MASK_ZVN  = 3'b111;
    localparam logic [2:0] MASK_Z    = 3'b100;
    localparam logic [2:0] MASK_NONE = 3'b000;

    function automatic logic [2:0] flag_wr_mask(input opcode_t opc);
        logic [2:0] mask;
        mask = MASK_NONE;
        case (opc)
            OP_ADD, OP_SUB:                 mask = MASK_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = MASK_Z;
            default:                        mask = MASK_NONE;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: decides whether condition code
// i_ccc is satisfied by the flag set i_flags.
module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] i_ccc,
    input  flags_t     i_flags,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (ccc_t'(i_ccc))
            CC_NE:  o_taken = ~i_flags.z;
            CC_EQ:  o_taken =  i_flags.z;
            CC_GT:  o_taken = ~i_flags.z & ~i_flags.n;
            CC_LT:  o_taken =  i_flags.n;
            CC_GE:  o_taken =  i_flags.z | ~i_flags.n;
            CC_LE:  o_taken =  i_flags.z |  i_flags.n;
            CC_OV:  o_taken =  i_flags.v;
            CC_UNC: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register with per-opcode write masks and branch resolution.
// FLAG_BYPASS_EN: forward EX flags to a dependent branch instead of stalling one cycle.
module flag_unit
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CC_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic [OPC_W-1:0] ex_opcode,
    input  logic             alu_zero,
    input  logic             alu_ovfl,
    input  logic             alu_neg,
    input  logic             id_br_valid,
    input  logic [CC_W-1:0]  id_ccc,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_taken,
    output logic             br_stall,
    output logic             dbg_state
);

    flags_t     r_flags;
    flags_t     w_alu;
    flags_t     w_next;
    flags_t     w_f;
    logic [2:0] w_we;
    logic       w_hazard;
    logic       w_cond;
    logic       w_stall;
    logic       w_gate;

    assign w_alu    = '{z: alu_zero, v: alu_ovfl, n: alu_neg};
    assign w_we     = {3{ex_valid & ~ex_flush}} & flag_wr_mask(opcode_t'(ex_opcode));
    assign w_next   = (w_we & w_alu) | (~w_we & r_flags);
    assign w_hazard = id_br_valid & (|w_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_next;
        end
    end

`ifdef FLAG_BYPASS_EN
    // When nothing writes, w_next equals the register, so it serves as F unconditionally.
    assign w_f       = w_next;
    assign w_stall   = 1'b0;
    assign w_gate    = 1'b1;
    assign dbg_state = 1'b0;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HOLD needs no hazard check: the stall put a bubble into EX.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_gate       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_hazard) begin
                    w_state_next = ST_HOLD;
                    w_stall      = 1'b1;
                    w_gate       = 1'b0;
                end
            end
            ST_HOLD: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_f       = r_flags;
    assign dbg_state = r_state;
`endif

    br_cond_eval u_br_cond_eval (
        .i_ccc   (id_ccc),
        .i_flags (w_f),
        .o_taken (w_cond)
    );

    assign flag_z   = r_flags.z;
    assign flag_v   = r_flags.v;
    assign flag_n   = r_flags.n;
    assign br_taken = ~rst & id_br_valid & w_cond & w_gate;
    assign br_stall = ~rst & w_stall;

endmodule

// File: tb/tb_flag_unit.sv
// Directed table-driven bench for flag_unit; expectations for both the stalling
// and the FLAG_BYPASS_EN build are carried in each vector.
module tb_flag_unit;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic       ex_flush;
    logic [3:0] ex_opcode;
    logic       alu_zero;
    logic       alu_ovfl;
    logic       alu_neg;
    logic       id_br_valid;
    logic [2:0] id_ccc;
    logic       flag_z;
    logic       flag_v;
    logic       flag_n;
    logic       br_taken;
    logic       br_stall;
    logic       dbg_state;

    int n_checks;
    int n_errors;

    flag_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_flush    (ex_flush),
        .ex_opcode   (ex_opcode),
        .alu_zero    (alu_zero),
        .alu_ovfl    (alu_ovfl),
        .alu_neg     (alu_neg),
        .id_br_valid (id_br_valid),
        .id_ccc      (id_ccc),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .flag_n      (flag_n),
        .br_taken    (br_taken),
        .br_stall    (br_stall),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ex_valid;
        logic       ex_flush;
        logic [3:0] op;
        logic [2:0] alu;      // {zero, ovfl, neg}
        logic       br_valid;
        logic [2:0] ccc;
        logic       tk_nb;    // br_taken, stalling build
        logic       st_nb;    // br_stall, stalling build
        logic       tk_by;    // br_taken, bypass build (stall always 0)
        logic [2:0] fl;       // {z, v, n} after the edge
        logic       hold_nb;  // state after the edge, stalling build
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic f, logic [3:0] op, logic [2:0] alu,
                                logic bv, logic [2:0] cc, logic tk_nb, logic st_nb,
                                logic tk_by, logic [2:0] fl, logic hold_nb);
        vec_t r;
        r.ex_valid = v;   r.ex_flush = f;  r.op = op;  r.alu = alu;
        r.br_valid = bv;  r.ccc = cc;      r.tk_nb = tk_nb;
        r.st_nb = st_nb;  r.tk_by = tk_by; r.fl = fl;  r.hold_nb = hold_nb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver
    task automatic drive(input vec_t v);
        ex_valid    = v.ex_valid;
        ex_flush    = v.ex_flush;
        ex_opcode   = v.op;
        alu_zero    = v.alu[2];
        alu_ovfl    = v.alu[1];
        alu_neg     = v.alu[0];
        id_br_valid = v.br_valid;
        id_ccc      = v.ccc;
    endtask

    function automatic logic bypass_build();
`ifdef FLAG_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        vec_t idle;
        logic exp_tk;
        logic exp_st;
        logic exp_hold;
        n_checks = 0;
        n_errors = 0;

        //     v  f  op    alu     bv cc      tknb stnb tkby fl      hold
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b000, 1, 0, 1, 3'b000, 0)); // NE, Z=0
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b001, 0, 0, 0, 3'b000, 0)); // EQ
        vecs.push_back(mk(0, 0, 4'h0, 3'b111, 0, 3'b111, 0, 0, 0, 3'b000, 0)); // no branch
        vecs.push_back(mk(1, 0, 4'h0, 3'b011, 0, 3'b000, 0, 0, 0, 3'b011, 0)); // ADD v,n
        vecs.push_back(mk(1, 0, 4'h2, 3'b100, 0, 3'b000, 0, 0, 0, 3'b111, 0)); // XOR keeps v,n
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b110, 1, 0, 1, 3'b111, 0)); // OV
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b010, 0, 0, 0, 3'b111, 0)); // GT
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b100, 1, 0, 1, 3'b111, 0)); // GE
        vecs.push_back(mk(1, 0, 4'h1, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0)); // SUB clears
        vecs.push_back(mk(1, 1, 4'h1, 3'b111, 1, 3'b001, 0, 0, 0, 3'b000, 0)); // flushed SUB
        vecs.push_back(mk(1, 0, 4'h8, 3'b111, 1, 3'b001, 0, 0, 0, 3'b000, 0)); // LW
        vecs.push_back(mk(1, 0, 4'h7, 3'b111, 1, 3'b001, 0, 0, 0, 3'b000, 0)); // PADDSB
        vecs.push_back(mk(1, 0, 4'h3, 3'b111, 1, 3'b001, 0, 0, 0, 3'b000, 0)); // RED
        vecs.push_back(mk(1, 0, 4'h1, 3'b100, 1, 3'b001, 0, 1, 1, 3'b100, 1)); // hazard SUB
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b001, 1, 0, 1, 3'b100, 0)); // HOLD cycle
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b011, 0, 0, 0, 3'b100, 0)); // LT
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b101, 1, 0, 1, 3'b100, 0)); // LE
        vecs.push_back(mk(0, 0, 4'h0, 3'b011, 0, 3'b000, 0, 0, 0, 3'b100, 0)); // bubble ADD
        vecs.push_back(mk(1, 0, 4'h6, 3'b011, 0, 3'b000, 0, 0, 0, 3'b000, 0)); // ROR z only
        vecs.push_back(mk(1, 0, 4'h0, 3'b010, 0, 3'b000, 0, 0, 0, 3'b010, 0)); // ADD
        vecs.push_back(mk(1, 0, 4'h1, 3'b001, 0, 3'b000, 0, 0, 0, 3'b001, 0)); // SUB last wins
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b110, 0, 0, 0, 3'b001, 0)); // OV
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b011, 1, 0, 1, 3'b001, 0)); // LT
        vecs.push_back(mk(1, 0, 4'h2, 3'b100, 1, 3'b101, 0, 1, 1, 3'b101, 1)); // hazard XOR
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b101, 1, 0, 1, 3'b101, 0)); // HOLD cycle
        vecs.push_back(mk(1, 0, 4'h4, 3'b000, 1, 3'b000, 0, 1, 1, 3'b001, 1)); // hazard SLL
        vecs.push_back(mk(0, 0, 4'h0, 3'b000, 1, 3'b111, 1, 0, 1, 3'b001, 0)); // HOLD, UNC
        vecs.push_back(mk(1, 0, 4'hF, 3'b111, 1, 3'b111, 1, 0, 1, 3'b001, 0)); // HLT no write

        idle = mk(0, 0, 4'h0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0);

        // reset: outputs quiet even with a branch presented
        rst = 1'b1;
        drive(idle);
        id_br_valid = 1'b1;
        id_ccc      = 3'b111;
        #3;
        chk("rst_flags", {1'b0, flag_z, flag_v, flag_n}, 4'h0);
        chk("rst_taken", {3'b0, br_taken}, 4'h0);
        chk("rst_stall", {3'b0, br_stall}, 4'h0);
        chk("rst_state", {3'b0, dbg_state}, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            exp_tk   = bypass_build() ? vecs[i].tk_by : vecs[i].tk_nb;
            exp_st   = bypass_build() ? 1'b0 : vecs[i].st_nb;
            exp_hold = bypass_build() ? 1'b0 : vecs[i].hold_nb;
            #1;
            chk($sformatf("v%0d_taken", i), {3'b0, br_taken}, {3'b0, exp_tk});
            chk($sformatf("v%0d_stall", i), {3'b0, br_stall}, {3'b0, exp_st});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_flags", i), {1'b0, flag_z, flag_v, flag_n}, {1'b0, vecs[i].fl});
            chk($sformatf("v%0d_state", i), {3'b0, dbg_state}, {3'b0, exp_hold});
        end

        // reset asserted in the middle of HOLD
        @(negedge clk);
        drive(mk(1, 0, 4'h0, 3'b111, 0, 3'b000, 0, 0, 0, 3'b000, 0));
        @(negedge clk);
        drive(mk(1, 0, 4'h1, 3'b001, 1, 3'b010, 0, 0, 0, 3'b000, 0));
        #1;
        chk("hz_stall", {3'b0, br_stall}, {3'b0, ~bypass_build()});
        @(posedge clk);
        #1;
        chk("hz_flags", {1'b0, flag_z, flag_v, flag_n}, 4'h1);
        chk("hz_state", {3'b0, dbg_state}, {3'b0, ~bypass_build()});
        drive(idle);
        id_br_valid = 1'b1;
        id_ccc      = 3'b010;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_flags", {1'b0, flag_z, flag_v, flag_n}, 4'h0);
        chk("mid_rst_state", {3'b0, dbg_state}, 4'h0);
        chk("mid_rst_taken", {3'b0, br_taken}, 4'h0);
        chk("mid_rst_stall", {3'b0, br_stall}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_gt_taken", {3'b0, br_taken}, 4'h1);
        chk("post_rst_gt_stall", {3'b0, br_stall}, 4'h0);
        @(posedge clk);
        #1;
        chk("post_rst_flags", {1'b0, flag_z, flag_v, flag_n}, 4'h0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
